// File: rtl/dmem_refill_responder.sv
// Main-memory responder for the data cache: fixed-latency block refills and write-through stores.
// Optional CRITICAL_WORD_FIRST_EN starts each refill burst at the requested word and wraps.
module dmem_refill_responder #(
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned LATENCY         = 4,
  parameter int unsigned ADDR_WORDS_LOG2 = 10
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_we,
  input  logic [31:0]                        req_addr,
  input  logic [31:0]                        req_wdata,
  output logic                               resp_valid,
  output logic [31:0]                        resp_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] resp_idx,
  output logic                               resp_last,
  output logic                               wr_done,
  output logic                               busy
);

  localparam int unsigned IdxW = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned AW   = ADDR_WORDS_LOG2;
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StWrite} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   beat_q, beat_d;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic [IdxW-1:0]   resp_idx_q, resp_idx_d;
  logic              resp_last_q, resp_last_d;
  logic              wr_done_q, wr_done_d;

  logic [31:0]       mem [2**AW];
  logic              accept;
  logic              emit;
  logic              mem_we;
  logic [IdxW-1:0]   start_idx;
  logic [AW-1:0]     rd_addr;
  logic              unused_addr;

  assign accept      = req_valid && (state_q == StIdle);
  assign rd_addr     = {addr_q[AW-1:IdxW], idx_q};
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_idx = req_addr[IdxW+1:2];
`else
  assign start_idx = '0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    beat_d       = beat_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_idx_d   = resp_idx_q;
    resp_last_d  = 1'b0;
    wr_done_d    = 1'b0;
    mem_we       = 1'b0;
    emit         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = CntW'(LATENCY - 1);
          idx_d   = start_idx;
          beat_d  = '0;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (we_q) begin
            state_d   = StWrite;
            mem_we    = 1'b1;
            wr_done_d = 1'b1;
          end else begin
            state_d = StBurst;
            emit    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StBurst: begin
        // The final word has already been registered; drop back to idle.
        if (resp_last_q) state_d = StIdle;
        else             emit    = 1'b1;
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (emit) begin
      resp_valid_d = 1'b1;
      resp_data_d  = mem[rd_addr];
      resp_idx_d   = idx_q;
      resp_last_d  = (beat_q == IdxW'(WORDS_PER_BLOCK - 1));
      idx_d        = idx_q + IdxW'(1);
      beat_d       = beat_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      beat_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_idx_q   <= '0;
      resp_last_q  <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      beat_q       <= beat_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_idx_q   <= resp_idx_d;
      resp_last_q  <= resp_last_d;
      wr_done_q    <= wr_done_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
      end
    end
  end

  // Gated by rstn so a commit edge that coincides with reset is discarded.
  always_ff @(posedge clk) begin
    if (mem_we && rstn) mem[addr_q] <= wdata_q;
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_idx   = resp_idx_q;
  assign resp_last  = resp_last_q;
  assign wr_done    = wr_done_q;

endmodule

// File: tb/tb_dmem_refill_responder.sv
// Directed bench for dmem_refill_responder (default parameters; honours CRITICAL_WORD_FIRST_EN).
module tb_dmem_refill_responder;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_idx;
  logic        resp_last;
  logic        wr_done;
  logic        busy;

  int tests = 0;
  int fails = 0;

  dmem_refill_responder dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_idx  (resp_idx),
    .resp_last (resp_last),
    .wr_done   (wr_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept a write and confirm wr_done fires exactly LATENCY=4 cycles later, then ready again.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    check("wr_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("wr_done", 32'(wr_done), 32'(k == 4));
    end
    check("wr_ready_after", 32'(req_ready), 32'd1);
  endtask

  // Accept a read and check the 4-beat burst starting at A+4; ed/ei index 0 is the first beat.
  task automatic do_read(input logic [31:0] a, input logic [3:0][31:0] ed,
                         input logic [3:0][1:0] ei);
    check("rd_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("rd_wait_valid", 32'(resp_valid), 32'd0);
      check("rd_wait_busy", 32'(busy), 32'd1);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("rd_valid", 32'(resp_valid), 32'd1);
      check("rd_data", resp_data, ed[b]);
      check("rd_idx", 32'(resp_idx), 32'(ei[b]));
      check("rd_last", 32'(resp_last), 32'(b == 3));
    end
    @(negedge clk);
    check("rd_end_valid", 32'(resp_valid), 32'd0);
    check("rd_end_last", 32'(resp_last), 32'd0);
    check("rd_end_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int beats;
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_wr_done", 32'(wr_done), 32'd0);
    check("rst_last", 32'(resp_last), 32'd0);
    check("rst_data", resp_data, 32'd0);
    check("rst_idx", 32'(resp_idx), 32'd0);

    do_write(32'h40, 32'hA0);
    do_write(32'h44, 32'hA1);
    do_write(32'h48, 32'hA2);
    do_write(32'h4C, 32'hA3);
    do_read(32'h40, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {2'd3, 2'd2, 2'd1, 2'd0});

`ifdef CRITICAL_WORD_FIRST_EN
    do_read(32'h48, {32'hA1, 32'hA0, 32'hA3, 32'hA2}, {2'd1, 2'd0, 2'd3, 2'd2});
`else
    do_read(32'h48, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {2'd3, 2'd2, 2'd1, 2'd0});
`endif

    // Request held valid through a burst: ignored while busy, re-accepted right after.
    beats = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      check("hold_ready_low", 32'(req_ready), 32'd0);
      if (resp_valid) beats++;
      @(negedge clk);
    end
    check("hold_beats", 32'(beats), 32'd4);
    check("hold_ready_high", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("hold_reaccepted", 32'(busy), 32'd1);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("hold_drained", 32'(req_ready), 32'd1);

    // Address aliasing: byte 0x1000 maps to word 0 with a 1024-word array.
    do_write(32'h4, 32'h11);
    do_write(32'h8, 32'h22);
    do_write(32'hC, 32'h33);
    do_write(32'h1000, 32'hDEADBEEF);
    do_read(32'h0, {32'h33, 32'h22, 32'h11, 32'hDEADBEEF}, {2'd3, 2'd2, 2'd1, 2'd0});

    // Reset two cycles into a write: the write must never commit.
    do_write(32'h80, 32'h77);
    do_write(32'h84, 32'h78);
    do_write(32'h88, 32'h79);
    do_write(32'h8C, 32'h7A);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rstw_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstw_no_wr_done", 32'(wr_done), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    check("rstw_no_wr_done_post", 32'(wr_done), 32'd0);
    do_read(32'h80, {32'h7A, 32'h79, 32'h78, 32'h77}, {2'd3, 2'd2, 2'd1, 2'd0});

    // Reset mid-burst: resp_valid drops immediately and no further words appear.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rstb_mid_valid", 32'(resp_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check("rstb_valid", 32'(resp_valid), 32'd0);
    check("rstb_last", 32'(resp_last), 32'd0);
    check("rstb_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rstb_quiet", 32'(resp_valid), 32'd0);
    end
    check("rstb_ready", 32'(req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_refill_responder.md
Name: dmem_refill_responder

Overview:
- Main-memory side of the data-cache interface; services requests from the Memory stage's data cache.
- Serves block refills: multi-word read bursts on a cache miss.
- Serves single-word write-through stores.
- Contains a word-addressed storage array, a fixed-latency countdown and a burst sequencer; models real memory timing for the pipeline.

Parameters:
- WORDS_PER_BLOCK, 4, words per refill burst; power of two, 2..16.
- LATENCY, 4, cycles from request acceptance to first response word / write commit; minimum 1.
- ADDR_WORDS_LOG2, 10, log2 of array depth in 32-bit words.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  cache presents a request.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = single-word write, 0 = block read.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_wdata  input  32  store data when req_we=1.
- resp_valid  output  1  resp_data holds a valid read word this cycle.
- resp_data  output  32  read word.
- resp_idx  output  log2(WORDS_PER_BLOCK)  word offset within block of resp_data.
- resp_last  output  1  final word of burst; asserted together with resp_valid.
- wr_done  output  1  one-cycle pulse when a write commits.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: async on rstn low.
  - State → IDLE.
  - req_ready=1 after reset release.
  - resp_valid, resp_last, wr_done, busy = 0; resp_data=0; resp_idx=0.
  - Array contents are not cleared.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready (cycle A).
  - req_we, the word address and req_wdata are latched at cycle A.
  - req_ready falls the following cycle.
  - No backpressure on responses; the cache must take every word.
- Address handling:
  - word_addr = req_addr[ADDR_WORDS_LOG2+1:2]; upper bits ignored (array aliases/wraps).
  - block_base = word_addr with its low log2(WORDS_PER_BLOCK) bits cleared.
- States:
  - IDLE → WAIT on acceptance.
  - WAIT: counter loaded with LATENCY-1, decrements each cycle. At 0: → BURST if read, → WRITE if write.
  - BURST: one word per cycle for WORDS_PER_BLOCK consecutive cycles.
    - resp_valid=1; resp_data = mem[block_base + idx]; resp_idx = idx.
    - idx runs 0..WORDS_PER_BLOCK-1.
    - resp_last=1 on the final word, then → IDLE.
  - WRITE: single cycle; mem[word_addr] <= wdata; wr_done=1; → IDLE.
- Timing: first resp_valid (or wr_done) is registered and appears exactly LATENCY cycles after cycle A.
- Back-to-back: req_ready is high the cycle after resp_last/wr_done. Minimum spacing between acceptances is LATENCY+WORDS_PER_BLOCK+1 cycles for a read, LATENCY+2 for a write.
- Read-after-write to the same word returns the new data.
- Outputs registered:
  - resp_data, resp_idx and resp_last hold their last values when resp_valid=0.
  - resp_last never asserts without resp_valid.
- Reset mid-operation: aborts immediately.
  - No further response words.
  - A write not yet in WRITE state is never committed.
  - A write whose commit edge coincides with rstn falling is also discarded.
- req_valid while busy is ignored (not queued).

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- Defined: the burst starts at the requested word offset and wraps modulo WORDS_PER_BLOCK within the block.
  - resp_idx reports each word's true offset.
  - resp_last marks the WORDS_PER_BLOCK-th word delivered, not offset WORDS_PER_BLOCK-1.
- Undefined: the burst always starts at offset 0, regardless of req_addr low bits.

Test Plan:
- Reset: hold rstn=0 over 3 edges → req_ready=1 after release, busy=0, resp_valid=0, wr_done=0.
- Write then read:
  - Writes of 0xA0,0xA1,0xA2,0xA3 to bytes 0x40,0x44,0x48,0x4C → each wr_done pulses exactly 4 cycles after its acceptance.
  - Read at 0x40 → resp_valid from cycle A+4 to A+7; data A0..A3; resp_idx 0..3; resp_last only at A+7.
- Critical word: read at 0x48.
  - Macro off → order A0,A1,A2,A3.
  - Macro on → A2,A3,A0,A1 with resp_idx 2,3,0,1; resp_last on A1.
- Ignored request: hold req_valid=1 through a burst → req_ready=0 throughout; exactly one burst; next acceptance on the cycle after resp_last.
- Aliasing: write 0xDEADBEEF to byte 0x1000 (ADDR_WORDS_LOG2=10) → read at 0x0000 returns 0xDEADBEEF as word 0.
- Reset mid-op:
  - Assert rstn low 2 cycles after accepting a write of 0x55 to 0x80 → no wr_done; a later read of 0x80 returns the prior value.
  - Assert rstn low mid-burst → resp_valid=0 immediately.
